// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states, width helper.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD    = 3'b000;
    localparam logic [2:0] MODE_LOAD    = 3'b001;
    localparam logic [2:0] MODE_SHL     = 3'b010;
    localparam logic [2:0] MODE_SHR     = 3'b011;
    localparam logic [2:0] MODE_ROL     = 3'b100;
    localparam logic [2:0] MODE_ROR     = 3'b101;
    localparam logic [2:0] MODE_SHL_SER = 3'b110;
    localparam logic [2:0] MODE_CLEAR   = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter width able to hold the value w (w >= 2)
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One-bit shift/rotate of q according to mode; bit_out is the bit leaving the register.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_q,
    output logic             bit_out
);

    // Single-step datapath; non-shift modes pass q through
    always_comb begin
        next_q  = q;
        bit_out = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], 1'b0};
                bit_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {1'b0, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_SHL_SER: begin
                next_q  = {q[WIDTH-2:0], ser_in};
                bit_out = q[WIDTH-1];
            end
            default: begin
                next_q  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with hold/load/clear and bit-serial multi-bit shift/rotate
// under a Start/Busy/Done handshake.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $unsigned(cnt_width(WIDTH))
) (
    input  logic             CK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [CNT_W-1:0] Amount,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
);

    state_t           state;
    logic [2:0]       mode_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] next_q;
    logic             bit_out;

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (Q),
        .mode    (mode_r),
        .ser_in  (SerIn),
        .next_q  (next_q),
        .bit_out (bit_out)
    );

    // Control FSM, shift counter and all registered outputs
    always_ff @(posedge CK or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            mode_r <= MODE_HOLD;
            cnt    <= '0;
            Q      <= '0;
            SerOut <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else if (!Enable) begin
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        case (Mode)
                            MODE_HOLD:  Done <= 1'b1;
                            MODE_LOAD: begin
                                Q    <= D;
                                Done <= 1'b1;
                            end
                            MODE_CLEAR: begin
                                Q    <= '0;
                                Done <= 1'b1;
                            end
                            default: begin
                                if (Amount == '0) begin
                                    Done <= 1'b1;
                                end else begin
                                    mode_r <= Mode;
                                    cnt    <= (Amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Amount;
                                    Busy   <= 1'b1;
                                    state  <= ST_SHIFT;
                                end
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    Q      <= next_q;
                    SerOut <= bit_out;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed testbench for universal_shift_reg (WIDTH=8).
module tb_universal_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100, M_ROR  = 3'b101, M_SER = 3'b110, M_CLR = 3'b111;

    logic             ck = 1'b0;
    logic             reset;
    logic             enable;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] d;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .CK     (ck),
        .Reset  (reset),
        .Enable (enable),
        .Start  (start),
        .Mode   (mode),
        .Amount (amount),
        .D      (d),
        .SerIn  (ser_in),
        .Q      (q),
        .SerOut (ser_out),
        .Busy   (busy),
        .Done   (done)
    );

    always #5 ck = ~ck;

    // Compare observed against expected and count the outcome
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Present a one-cycle Start request
    task automatic do_start(input logic [2:0] m, input logic [CNT_W-1:0] a, input logic [WIDTH-1:0] data);
        start  = 1'b1;
        mode   = m;
        amount = a;
        d      = data;
        tick();
        start  = 1'b0;
        mode   = M_HOLD;
        amount = '0;
        d      = '0;
    endtask

    // Count edges until Done, bounded
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [7:0] ser_bits;
        ser_bits = 8'b1011_0010;

        reset = 1'b1; enable = 1'b1; start = 1'b0; mode = M_HOLD;
        amount = '0; d = '0; ser_in = 1'b0;
        tick(); tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_serout", 32'(ser_out), 32'd0);
        reset = 1'b0;
        tick();

        // LOAD A5: single cycle, Done pulse, no Busy
        do_start(M_LOAD, 4'd0, 8'hA5);
        check("load_q", 32'(q), 32'hA5);
        check("load_done", 32'(done), 32'd1);
        check("load_busy", 32'(busy), 32'd0);
        tick();
        check("load_done_clr", 32'(done), 32'd0);

        // ROL 5 from A5, async reset after two shifts
        do_start(M_ROL, 4'd5, 8'h00);
        check("rol5_busy", 32'(busy), 32'd1);
        check("rol5_noshift", 32'(q), 32'hA5);
        tick();
        check("rol5_s1_q", 32'(q), 32'h4B);
        check("rol5_s1_so", 32'(ser_out), 32'd1);
        tick();
        check("rol5_s2_q", 32'(q), 32'h96);
        #2 reset = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h00);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_so", 32'(ser_out), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check("arst_post_done", 32'(done), 32'd0);
        check("arst_post_busy", 32'(busy), 32'd0);

        // 81 ROL 3 -> 0C; last bit out is MSB of 06, i.e. 0
        do_start(M_LOAD, 4'd0, 8'h81);
        do_start(M_ROL, 4'd3, 8'h00);
        check("rol3_busy", 32'(busy), 32'd1);
        wait_done("rol3", cyc);
        check("rol3_cycles", 32'(cyc), 32'd3);
        check("rol3_q", 32'(q), 32'h0C);
        check("rol3_so", 32'(ser_out), 32'd0);
        check("rol3_busy_end", 32'(busy), 32'd0);

        // F0 SHR 2 with a two-cycle enable stall after the first shift
        do_start(M_LOAD, 4'd0, 8'hF0);
        do_start(M_SHR, 4'd2, 8'h00);
        tick();
        check("shr_s1_q", 32'(q), 32'h78);
        enable = 1'b0;
        tick(); tick();
        check("stall_q", 32'(q), 32'h78);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_done", 32'(done), 32'd0);
        enable = 1'b1;
        tick();
        check("shr_q", 32'(q), 32'h3C);
        check("shr_done", 32'(done), 32'd1);

        // SHL_SER 8 fed with 1,0,1,1,0,0,1,0
        do_start(M_SER, 4'd8, 8'h00);
        for (int i = 0; i < 8; i++) begin
            ser_in = ser_bits[7 - i];
            tick();
            if (i == 6) check("ser_busy_mid", 32'(busy), 32'd1);
        end
        ser_in = 1'b0;
        check("ser_q", 32'(q), 32'hB2);
        check("ser_done", 32'(done), 32'd1);

        // SHL 12 clamps to 8 shifts -> zero
        do_start(M_SHL, 4'd12, 8'h00);
        wait_done("shl12", cyc);
        check("shl12_cycles", 32'(cyc), 32'd8);
        check("shl12_q", 32'(q), 32'h00);

        // ROL 9 clamps to 8 -> original value
        do_start(M_LOAD, 4'd0, 8'h6D);
        do_start(M_ROL, 4'd9, 8'h00);
        wait_done("rol9", cyc);
        check("rol9_cycles", 32'(cyc), 32'd8);
        check("rol9_q", 32'(q), 32'h6D);

        // Start while Busy ignored; back-to-back ROR 0 acts as HOLD
        do_start(M_LOAD, 4'd0, 8'h0C);
        do_start(M_SHL, 4'd2, 8'h00);
        tick();
        check("b2b_s1_q", 32'(q), 32'h18);
        do_start(M_LOAD, 4'd0, 8'hFF);
        check("busy_start_q", 32'(q), 32'h30);
        check("busy_start_done", 32'(done), 32'd1);
        do_start(M_ROR, 4'd0, 8'h00);
        check("ror0_done", 32'(done), 32'd1);
        check("ror0_q", 32'(q), 32'h30);
        check("ror0_busy", 32'(busy), 32'd0);
        tick();
        check("ror0_done_clr", 32'(done), 32'd0);

        // CLEAR leaves SerOut untouched
        do_start(M_CLR, 4'd0, 8'h00);
        check("clr_q", 32'(q), 32'h00);
        check("clr_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
